// File: rtl/imem_loader.sv
// Boot loader: assembles a framed byte stream into 32-bit words, writes them into IMEM,
// verifies an XOR checksum and releases the CPU from reset only after a clean load.
//
// state    | meaning
// S_LEN_HI | waiting for the high byte of the word count
// S_LEN_LO | waiting for the low byte; validates the word count
// S_DATA   | assembling data bytes into words and writing them to IMEM
// S_CSUM   | waiting for the checksum byte
// S_DONE   | image loaded and verified; CPU released
// S_ERR    | load aborted; CPU held in reset
module imem_loader #(
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  im_we,
  output logic [DEPTH_LOG2-1:0] im_waddr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  err
);

  localparam int WCW = DEPTH_LOG2 + 1;
  localparam logic [16:0] MAX_WORDS = 17'd1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      len_hi;
  logic [7:0]      csum;
  logic [16:0]     n_words;
  logic [1:0]      byte_cnt;
  logic [WCW-1:0]  word_cnt;
  logic [23:0]     asm_q;

  logic            accept;
  logic [16:0]     len_rx;
  logic            len_bad;
  logic            last_word;
  logic            csum_ok;

  assign accept    = in_valid && in_ready;
  assign len_rx    = {1'b0, len_hi, in_data};
  assign len_bad   = (len_rx == 17'd0) || (len_rx > MAX_WORDS);
  assign last_word = (17'(word_cnt) == (n_words - 17'd1));
  assign csum_ok   = (csum == in_data);

  always_ff @(posedge clk) begin
    if (rst) state <= S_LEN_HI;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (accept) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (accept) state_nxt = len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (accept && (byte_cnt == 2'd3) && last_word) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        in_ready = 1'b1;
        if (accept) state_nxt = csum_ok ? S_DONE : S_ERR;
      end
      default: ;
    endcase
  end

  // Status flags are registered from the next state so they change together with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi   <= '0;
      csum     <= '0;
      n_words  <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
      asm_q    <= '0;
      im_we    <= 1'b0;
      im_waddr <= '0;
      im_wdata <= '0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      im_we   <= 1'b0;
      cpu_rst <= (state_nxt != S_DONE);
      done    <= (state_nxt == S_DONE);
      err     <= (state_nxt == S_ERR);
      if (accept) begin
        case (state)
          S_LEN_HI: len_hi <= in_data;
          S_LEN_LO: begin
            n_words  <= len_rx;
            byte_cnt <= '0;
            word_cnt <= '0;
            csum     <= '0;
            asm_q    <= '0;
          end
          S_DATA: begin
            csum     <= csum ^ in_data;
            asm_q    <= {asm_q[15:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              im_we    <= 1'b1;
              im_waddr <= word_cnt[DEPTH_LOG2-1:0];
              im_wdata <= {asm_q, in_data};
              word_cnt <= word_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frames for imem_loader, checked against a word/XOR model
// of the frame format.
module tb_imem_loader;
  localparam int DL = 11;
  localparam int MAXW = 1 << DL;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          im_we;
  logic [DL-1:0] im_waddr;
  logic [31:0]   im_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  imem_loader #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int failed = 0;

  logic [DL-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  logic [31:0]   src[$];

  always @(negedge clk) begin
    if (im_we) begin
      got_addr.push_back(im_waddr);
      got_data.push_back(im_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_im_we"},    32'(im_we),    32'd0);
    check({tag, "_im_waddr"}, 32'(im_waddr), 32'd0);
    check({tag, "_im_wdata"}, im_wdata,      32'd0);
    check({tag, "_cpu_rst"},  32'(cpu_rst),  32'd1);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
  endtask

  // Sends LEN, the words in src and a checksum of (XOR of data bytes) ^ delta,
  // then compares the IMEM writes and final status against the frame rules.
  task automatic run_frame(input string tag, input int n_len, input logic [7:0] delta,
                           input bit gaps, input bit do_reset);
    bit         legal;
    logic [7:0] x;
    logic [7:0] b;
    int         gap;
    legal = (n_len >= 1) && (n_len <= MAXW);
    if (do_reset) pulse_reset();
    got_addr.delete();
    got_data.delete();
    send_byte(8'(n_len >> 8), 0);
    send_byte(8'(n_len), 0);
    if (!legal) begin
      check({tag, "_err"},      32'(err),      32'd1);
      check({tag, "_done"},     32'(done),     32'd0);
      check({tag, "_cpu_rst"},  32'(cpu_rst),  32'd1);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      repeat (3) @(negedge clk);
      check({tag, "_writes"},   32'(got_addr.size()), 32'd0);
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n_len; w++) begin
      for (int k = 3; k >= 0; k--) begin
        b = 8'(src[w] >> (8 * k));
        x ^= b;
        gap = (gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        send_byte(b, gap);
      end
    end
    @(negedge clk);
    check({tag, "_pre_done"},    32'(done),    32'd0);
    check({tag, "_pre_cpu_rst"}, 32'(cpu_rst), 32'd1);
    send_byte(x ^ delta, 0);
    check({tag, "_done"},     32'(done),     32'(delta == 8'h00));
    check({tag, "_err"},      32'(err),      32'(delta != 8'h00));
    check({tag, "_cpu_rst"},  32'(cpu_rst),  32'(delta != 8'h00));
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_writes"}, 32'(got_addr.size()), 32'(n_len));
    for (int i = 0; i < n_len && i < got_addr.size(); i++) begin
      check({tag, "_addr"}, 32'(got_addr[i]), 32'(i));
      check({tag, "_data"}, got_data[i], src[i]);
    end
    check({tag, "_hold_addr"}, 32'(im_waddr), 32'(n_len - 1));
    check({tag, "_hold_data"}, im_wdata, src[n_len - 1]);
    check({tag, "_we_idle"},   32'(im_we), 32'd0);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");

    src.delete();
    src.push_back(32'h3C011234);
    run_frame("n1_ok", 1, 8'h00, 1'b0, 1'b1);
    run_frame("n1_badcsum", 1, 8'h1B, 1'b0, 1'b1);

    run_frame("len_zero", 0, 8'h00, 1'b0, 1'b1);
    run_frame("len_2049", 2049, 8'h00, 1'b0, 1'b1);

    src.delete();
    for (int i = 0; i < MAXW; i++) src.push_back($urandom);
    run_frame("n2048", MAXW, 8'h00, 1'b1, 1'b1);

    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 6));
      src.delete();
      for (int i = 0; i < n; i++) src.push_back($urandom);
      run_frame("rand", n, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
                1'b1, 1'b1);
    end

    // Reset while a word is partially assembled; the byte on the reset edge is dropped.
    pulse_reset();
    got_addr.delete();
    got_data.delete();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hDD;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check_reset_values("midrst");
    repeat (3) @(negedge clk);
    check("midrst_writes", 32'(got_addr.size()), 32'd0);
    src.delete();
    src.push_back(32'hDEADBEEF);
    run_frame("after_rst", 1, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
